// File: rtl/prbs7_checker.sv
// Serial PRBS7 checker: self-synchronises to b[t+7] = b[t]^b[t+1]^b[t+2]^b[t+3],
// declares lock after LOCK_CNT good checks and counts mismatches while locked.
module prbs7_checker #(
    parameter int LOCK_CNT    = 16,
    parameter int LOSS_THRESH = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    input  logic             in_bit,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(LOSS_THRESH + 1);
    localparam logic [GW-1:0]    LOCK_TGT = GW'(LOCK_CNT);
    localparam logic [MW-1:0]    LOSS_TGT = MW'(LOSS_THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        FILL,
        HUNT,
        LOCKED
    } state_t;

    state_t        state;
    logic [6:0]    hist;
    logic [2:0]    fill_cnt;
    logic [GW-1:0] good_run;
    logic [MW-1:0] miss_run;

    logic          predict;
    logic          good_chk;
    logic [GW-1:0] good_nxt;
    logic [MW-1:0] miss_nxt;

    // An all-zero history never counts as good, so a stuck-at-0 line cannot lock.
    assign predict  = ^hist[3:0];
    assign good_chk = (in_bit == predict) && (hist != 7'd0);
    assign good_nxt = good_run + GW'(1);
    assign miss_nxt = miss_run + MW'(1);

    // History shifts on every valid bit regardless of state; clr is applied last so it
    // overrides a same-cycle increment while err_pulse still reports the mismatch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FILL;
            hist      <= 7'd0;
            fill_cnt  <= 3'd0;
            good_run  <= '0;
            miss_run  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (in_val) begin
                hist <= {in_bit, hist[6:1]};
                case (state)
                    FILL: begin
                        if (fill_cnt == 3'd6) begin
                            state    <= HUNT;
                            good_run <= '0;
                            fill_cnt <= 3'd7;
                        end else begin
                            fill_cnt <= fill_cnt + 3'd1;
                        end
                    end
                    HUNT: begin
                        if (good_chk) begin
                            good_run <= good_nxt;
                            if (good_nxt == LOCK_TGT) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                miss_run <= '0;
                            end
                        end else begin
                            good_run <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!good_chk) begin
                            err_pulse <= 1'b1;
                            miss_run  <= miss_nxt;
                            if (err_count != CNT_MAX) begin
                                err_count <= err_count + CNT_W'(1);
                            end
                            if (miss_nxt == LOSS_TGT) begin
                                state    <= HUNT;
                                locked   <= 1'b0;
                                good_run <= '0;
                            end
                        end else begin
                            miss_run <= '0;
                        end
                    end
                    default: state <= FILL;
                endcase
            end
            if (clr) begin
                err_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prbs7_checker.sv
// Directed bench for prbs7_checker: default instance plus a CNT_W=3 instance sharing
// the same stimulus to exercise counter saturation.
module tb_prbs7_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_val;
    logic        in_bit;
    logic        clr;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic        locked2;
    logic        err_pulse2;
    logic [2:0]  err_count2;

    int   checks = 0;
    int   errors = 0;
    logic seq [0:2047];
    int   idx;

    always #5 clk = ~clk;

    prbs7_checker dut (
        .clk       (clk),
        .reset     (reset),
        .in_val    (in_val),
        .in_bit    (in_bit),
        .clr       (clr),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    prbs7_checker #(.CNT_W(3)) dut_sat (
        .clk       (clk),
        .reset     (reset),
        .in_val    (in_val),
        .in_bit    (in_bit),
        .clr       (clr),
        .locked    (locked2),
        .err_pulse (err_pulse2),
        .err_count (err_count2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after an edge; outputs are sampled 1 unit after the next edge.
    task automatic applyStimulus(input logic v, input logic b, input logic c);
        in_val = v;
        in_bit = b;
        clr    = c;
        @(posedge clk);
        #1;
        in_val = 1'b0;
        clr    = 1'b0;
    endtask

    task automatic sendBit(input logic invert, input logic c);
        applyStimulus(1'b1, seq[idx] ^ invert, c);
        idx++;
    endtask

    task automatic doReset();
        reset  = 1'b0;
        in_val = 1'b0;
        in_bit = 1'b0;
        clr    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        idx   = 0;
    endtask

    initial begin
        logic [6:0]  seed;
        logic [10:0] mask;
        logic        early;
        logic        gap_pulse;
        int          pulses;
        int          vc;

        seed = 7'b1110001;
        for (int i = 0; i < 7; i++) seq[i] = seed[i];
        for (int i = 7; i < 2048; i++) seq[i] = seq[i-7] ^ seq[i-6] ^ seq[i-5] ^ seq[i-4];

        reset  = 1'b0;
        in_val = 1'b0;
        in_bit = 1'b0;
        clr    = 1'b0;
        #2;
        checkOutput("reset_locked", 32'(locked), 0);
        checkOutput("reset_pulse", 32'(err_pulse), 0);
        checkOutput("reset_count", 32'(err_count), 0);
        checkOutput("reset_count_sat", 32'(err_count2), 0);

        // Continuous stream from reset: lock on the 23rd bit, no errors over 500 bits.
        doReset();
        early  = 1'b0;
        pulses = 0;
        for (int i = 1; i <= 500; i++) begin
            sendBit(1'b0, 1'b0);
            if (i <= 22 && locked) early = 1'b1;
            if (i == 23) checkOutput("lock_at_23", 32'(locked), 1);
            pulses += int'(err_pulse);
        end
        checkOutput("no_early_lock", 32'(early), 0);
        checkOutput("clean_pulses", 32'(pulses), 0);
        checkOutput("clean_count", 32'(err_count), 0);
        checkOutput("clean_locked_500", 32'(locked), 1);

        // Gapped stream: valid every third cycle, garbage on in_bit during gaps.
        doReset();
        early     = 1'b0;
        gap_pulse = 1'b0;
        vc        = 0;
        for (int c = 0; c < 200 && vc < 23; c++) begin
            if (c % 3 == 0) begin
                sendBit(1'b0, 1'b0);
                vc++;
                if (vc <= 22 && locked) early = 1'b1;
            end else begin
                applyStimulus(1'b0, 1'($urandom_range(1, 0)), 1'b0);
                gap_pulse |= err_pulse;
                if (vc <= 22 && locked) early = 1'b1;
            end
        end
        checkOutput("gap_valid_bits", 32'(vc), 23);
        checkOutput("gap_no_early_lock", 32'(early), 0);
        checkOutput("gap_lock_at_23", 32'(locked), 1);
        checkOutput("gap_pulse_idle", 32'(gap_pulse), 0);
        checkOutput("gap_count", 32'(err_count), 0);

        // Single flipped bit: pulses at offsets 0,4,5,6,7.
        repeat (20) sendBit(1'b0, 1'b0);
        mask = '0;
        sendBit(1'b1, 1'b0);
        mask[0] = err_pulse;
        for (int j = 1; j <= 10; j++) begin
            sendBit(1'b0, 1'b0);
            mask[j] = err_pulse;
        end
        checkOutput("flip_pulse_mask", 32'(mask), 32'h0F1);
        checkOutput("flip_count", 32'(err_count), 5);
        checkOutput("flip_locked", 32'(locked), 1);

        // Inverted stream: mixed history gives good checks at offsets 4 and 6, clr there.
        repeat (10) sendBit(1'b0, 1'b0);
        mask = '0;
        for (int j = 0; j <= 5; j++) begin
            sendBit(1'b1, 1'b0);
            mask[j] = err_pulse;
        end
        checkOutput("inv_count_pre_clr", 32'(err_count), 10);
        checkOutput("inv_sat_count", 32'(err_count2), 7);
        sendBit(1'b1, 1'b1);
        mask[6] = err_pulse;
        checkOutput("inv_head_mask", 32'(mask), 32'h02F);
        checkOutput("inv_clr_count", 32'(err_count), 0);
        pulses = 0;
        for (int j = 7; j <= 14; j++) begin
            sendBit(1'b1, 1'b0);
            pulses += int'(err_pulse);
            if (j == 13) checkOutput("inv_locked_7th", 32'(locked), 1);
        end
        checkOutput("inv_unlock_8th", 32'(locked), 0);
        checkOutput("inv_unlock_sat", 32'(locked2), 0);
        checkOutput("inv_pulses", 32'(pulses), 8);
        checkOutput("inv_count", 32'(err_count), 8);
        checkOutput("inv_count_sat", 32'(err_count2), 7);

        // Restore true stream: relock on the 23rd true bit, no counting while hunting.
        for (int j = 0; j <= 22; j++) begin
            sendBit(1'b0, 1'b0);
            if (j == 21) checkOutput("relock_not_yet", 32'(locked), 0);
        end
        checkOutput("relock", 32'(locked), 1);
        checkOutput("relock_count", 32'(err_count), 8);

        // Second burst: wide counter keeps counting, 3-bit counter holds at 7.
        repeat (10) sendBit(1'b0, 1'b0);
        repeat (15) sendBit(1'b1, 1'b0);
        checkOutput("burst2_unlock", 32'(locked), 0);
        checkOutput("burst2_count", 32'(err_count), 21);
        checkOutput("burst2_count_sat", 32'(err_count2), 7);
        repeat (23) sendBit(1'b0, 1'b0);
        checkOutput("burst2_relock", 32'(locked), 1);
        checkOutput("burst2_relock_sat", 32'(locked2), 1);

        // clr coinciding with a counted mismatch: clear wins, pulse still fires.
        repeat (10) sendBit(1'b0, 1'b0);
        sendBit(1'b1, 1'b1);
        checkOutput("clr_pulse", 32'(err_pulse), 1);
        checkOutput("clr_pulse_sat", 32'(err_pulse2), 1);
        checkOutput("clr_count", 32'(err_count), 0);
        checkOutput("clr_count_sat", 32'(err_count2), 0);
        repeat (7) sendBit(1'b0, 1'b0);
        checkOutput("clr_after_count", 32'(err_count), 4);
        checkOutput("clr_after_locked", 32'(locked), 1);

        // Asynchronous reset between edges.
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("async_locked", 32'(locked), 0);
        checkOutput("async_count", 32'(err_count), 0);
        checkOutput("async_count_sat", 32'(err_count2), 0);

        // Stuck-at-0 line must never lock.
        doReset();
        early  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            if (locked) early = 1'b1;
            pulses += int'(err_pulse);
        end
        checkOutput("stuck_no_lock", 32'(early), 0);
        checkOutput("stuck_pulses", 32'(pulses), 0);
        checkOutput("stuck_count", 32'(err_count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
